tow_round_ctrl: RTL and testbench

- Consumer and controller for the push-button race latch. It takes the latch's push/tie/right verdict, waits for the race to settle, and scores the round by moving the rope position one step toward the winner.
- It drives the latch's clear input to re-arm it after each point.
- It detects game end, holds the winner until a new game is requested, and drives the rope LED bar.

---
 rtl/tow_pkg.sv | 28 ++
 rtl/tow_timer.sv | 37 +++
 rtl/tow_round_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tow_round_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war round controller:
// FSM state encoding, default geometry and width helpers.
package tow_pkg;

    typedef enum logic [2:0] {
        ST_ARMED    = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_SCORE    = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_OVER     = 3'd4
    } state_e;

    localparam int DEF_ROPE_LEN     = 9;
    localparam int DEF_SETTLE_CYC   = 16;
    localparam int DEF_COOLDOWN_CYC = 2500000;

    function automatic int centre_pos(input int rope_len);
        return (rope_len - 1) / 2;
    endfunction

    // The timer only ever holds 0..max-1, so clog2(max) bits are enough.
    function automatic int timer_w(input int settle_cyc, input int cooldown_cyc);
        int m;
        m = (settle_cyc > cooldown_cyc) ? settle_cyc : cooldown_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tow_timer.sv
// Loadable up-counter shared by the settle and cooldown phases; clears to zero,
// counts while enabled and parks on the terminal value.
module tow_timer
    import tow_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == term_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tow_round_ctrl.sv
// Round controller for the push-button race latch: settles and scores each
// verdict, re-arms the latch via clear, tracks rope position and game end.
module tow_round_ctrl
    import tow_pkg::*;
#(
    parameter int ROPE_LEN     = DEF_ROPE_LEN,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC,
    parameter int POS_W        = $clog2(ROPE_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                tie,
    input  logic                right,
    input  logic                new_game,
    output logic                clear,
    output logic [POS_W-1:0]    pos,
    output logic [ROPE_LEN-1:0] rope_led,
    output logic                point_left,
    output logic                point_right,
    output logic                point_tie,
    output logic                game_over,
    output logic                left_wins,
    output logic                right_wins
);

    localparam int                TW          = timer_w(SETTLE_CYC, COOLDOWN_CYC);
    localparam int                CENTRE_I    = centre_pos(ROPE_LEN);
    localparam logic [POS_W-1:0]  CENTRE      = POS_W'(CENTRE_I);
    localparam logic [POS_W-1:0]  POS_MAX     = POS_W'(ROPE_LEN - 1);
    localparam logic [TW-1:0]     SETTLE_TERM = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]     COOL_TERM   = TW'(COOLDOWN_CYC - 1);
    localparam logic [ROPE_LEN-1:0] LED_CENTRE =
        {{(ROPE_LEN-1){1'b0}}, 1'b1} << CENTRE_I;

    state_e              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [ROPE_LEN-1:0] led_q, led_d;
    logic                clear_q, clear_d;
    logic                pl_q, pl_d;
    logic                pr_q, pr_d;
    logic                pt_q, pt_d;
    logic                over_q, over_d;
    logic                lw_q, lw_d;
    logic                rw_q, rw_d;

    logic                tmr_clr;
    logic                tmr_en;
    logic                tmr_tc;
    logic [TW-1:0]       tmr_term;

    tow_timer #(
        .W (TW)
    ) u_timer (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .term_i (tmr_term),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        clear_d  = clear_q;
        pl_d     = 1'b0;
        pr_d     = 1'b0;
        pt_d     = 1'b0;
        over_d   = over_q;
        lw_d     = lw_q;
        rw_d     = rw_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        tmr_term = (state_q == ST_SETTLE) ? SETTLE_TERM : COOL_TERM;

        if (new_game) begin
            state_d = ST_COOLDOWN;
            tmr_clr = 1'b1;
            pos_d   = CENTRE;
            clear_d = 1'b1;
            over_d  = 1'b0;
            lw_d    = 1'b0;
            rw_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    clear_d = 1'b0;
                    if (push) begin
                        state_d = ST_SETTLE;
                        tmr_clr = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    tmr_en = 1'b1;
                    if (!push) begin
                        state_d = ST_ARMED;
                    end else if (tmr_tc) begin
                        // Verdict is taken here so pulse and pos appear together in SCORE.
                        state_d = ST_SCORE;
                        if (tie) begin
                            pt_d = 1'b1;
                        end else if (right) begin
                            pr_d = 1'b1;
                            if (pos_q != POS_MAX) pos_d = pos_q + POS_W'(1);
                        end else begin
                            pl_d = 1'b1;
                            if (pos_q != '0) pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                ST_SCORE: begin
                    clear_d = 1'b1;
                    if (pos_q == '0 || pos_q == POS_MAX) begin
                        state_d = ST_OVER;
                        over_d  = 1'b1;
                        lw_d    = (pos_q == '0);
                        rw_d    = (pos_q == POS_MAX);
                    end else begin
                        state_d = ST_COOLDOWN;
                        tmr_clr = 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    clear_d = 1'b1;
                    tmr_en  = 1'b1;
                    if (tmr_tc) begin
                        state_d = ST_ARMED;
                        clear_d = 1'b0;
                    end
                end
                ST_OVER: begin
                    clear_d = 1'b1;
                    over_d  = 1'b1;
                end
                default: begin
                    state_d = ST_COOLDOWN;
                    tmr_clr = 1'b1;
                    clear_d = 1'b1;
                end
            endcase
        end

        for (int i = 0; i < ROPE_LEN; i++) begin
            led_d[i] = (pos_d == POS_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_COOLDOWN;
            pos_q   <= CENTRE;
            led_q   <= LED_CENTRE;
            clear_q <= 1'b1;
            pl_q    <= 1'b0;
            pr_q    <= 1'b0;
            pt_q    <= 1'b0;
            over_q  <= 1'b0;
            lw_q    <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            clear_q <= clear_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            pt_q    <= pt_d;
            over_q  <= over_d;
            lw_q    <= lw_d;
            rw_q    <= rw_d;
        end
    end

    assign clear       = clear_q;
    assign pos         = pos_q;
    assign rope_led    = led_q;
    assign point_left  = pl_q;
    assign point_right = pr_q;
    assign point_tie   = pt_q;
    assign game_over   = over_q;
    assign left_wins   = lw_q;
    assign right_wins  = rw_q;

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Directed bench for tow_round_ctrl with SETTLE_CYC=4, COOLDOWN_CYC=8, ROPE_LEN=9.
module tb_tow_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       tie = 1'b0;
    logic       right = 1'b0;
    logic       new_game = 1'b0;
    logic       clear;
    logic [3:0] pos;
    logic [8:0] rope_led;
    logic       point_left, point_right, point_tie;
    logic       game_over, left_wins, right_wins;

    int errors = 0;
    int checks = 0;

    tow_round_ctrl #(
        .ROPE_LEN     (9),
        .SETTLE_CYC   (4),
        .COOLDOWN_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .tie         (tie),
        .right       (right),
        .new_game    (new_game),
        .clear       (clear),
        .pos         (pos),
        .rope_led    (rope_led),
        .point_left  (point_left),
        .point_right (point_right),
        .point_tie   (point_tie),
        .game_over   (game_over),
        .left_wins   (left_wins),
        .right_wins  (right_wins)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        int hi;
        rst = 1'b0;
        tick(2);
        if (clear !== 1'b1) begin errors++; $display("FAIL reset_clear got=%b exp=1", clear); end
        checks++;
        if (pos !== 4'd4) begin errors++; $display("FAIL reset_pos got=%0d exp=4", pos); end
        checks++;
        if (rope_led !== 9'b000010000) begin errors++; $display("FAIL reset_led got=%b exp=000010000", rope_led); end
        checks++;
        if ({point_left, point_right, point_tie, game_over, left_wins, right_wins} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=000000",
                {point_left, point_right, point_tie, game_over, left_wins, right_wins});
        end
        checks++;
        rst = 1'b1;
        hi = 0;
        repeat (7) begin
            tick(1);
            if (clear) hi++;
        end
        if (hi !== 7) begin errors++; $display("FAIL reset_cooldown_hi got=%0d exp=7", hi); end
        checks++;
        tick(1);
        if (clear !== 1'b0) begin errors++; $display("FAIL reset_armed_clear got=%b exp=0", clear); end
        checks++;
    endtask

    task automatic test_right_point;
        int hi;
        push = 1'b1; right = 1'b1; tie = 1'b0;
        tick(4);
        if (pos !== 4'd4 || point_right !== 1'b0) begin
            errors++; $display("FAIL right_early got pos=%0d pr=%b exp pos=4 pr=0", pos, point_right);
        end
        checks++;
        tick(1);
        if (pos !== 4'd5 || point_right !== 1'b1) begin
            errors++; $display("FAIL right_score got pos=%0d pr=%b exp pos=5 pr=1", pos, point_right);
        end
        checks++;
        if (rope_led !== 9'b000100000) begin errors++; $display("FAIL right_led got=%b exp=000100000", rope_led); end
        checks++;
        push = 1'b0; right = 1'b0;
        tick(1);
        if (point_right !== 1'b0 || clear !== 1'b1) begin
            errors++; $display("FAIL right_pulse_end got pr=%b clear=%b exp pr=0 clear=1", point_right, clear);
        end
        checks++;
        hi = 1;
        repeat (7) begin
            tick(1);
            if (clear) hi++;
        end
        if (hi !== 8) begin errors++; $display("FAIL right_clear_len got=%0d exp=8", hi); end
        checks++;
        tick(1);
        if (clear !== 1'b0) begin errors++; $display("FAIL right_rearm got=%b exp=0", clear); end
        checks++;
    endtask

    task automatic test_tie_late;
        push = 1'b1; right = 1'b1; tie = 1'b0;
        tick(2);
        tie = 1'b1;
        tick(3);
        if ({point_left, point_right, point_tie} !== 3'b001) begin
            errors++; $display("FAIL tie_pulse got=%b exp=001", {point_left, point_right, point_tie});
        end
        checks++;
        if (pos !== 4'd5) begin errors++; $display("FAIL tie_pos got=%0d exp=5", pos); end
        checks++;
        push = 1'b0; tie = 1'b0; right = 1'b0;
        tick(9);
        if (clear !== 1'b0) begin errors++; $display("FAIL tie_rearm got=%b exp=0", clear); end
        checks++;
    endtask

    task automatic test_glitch;
        int seen;
        push = 1'b1; right = 1'b0;
        tick(2);
        push = 1'b0;
        seen = 0;
        repeat (7) begin
            tick(1);
            if (point_left | point_right | point_tie) seen++;
            if (clear) seen++;
        end
        if (seen !== 0) begin errors++; $display("FAIL glitch_activity got=%0d exp=0", seen); end
        checks++;
        if (pos !== 4'd5) begin errors++; $display("FAIL glitch_pos got=%0d exp=5", pos); end
        checks++;
    endtask

    task automatic test_left_to_over;
        int seen;
        for (int k = 1; k <= 5; k++) begin
            push = 1'b1; right = 1'b0;
            tick(5);
            if (pos !== 4'(5 - k) || point_left !== 1'b1) begin
                errors++; $display("FAIL left_step%0d got pos=%0d pl=%b exp pos=%0d pl=1", k, pos, point_left, 5 - k);
            end
            checks++;
            push = 1'b0;
            if (k < 5) tick(9);
        end
        tick(1);
        if ({game_over, left_wins, right_wins, clear} !== 4'b1101) begin
            errors++; $display("FAIL over_left_flags got=%b exp=1101", {game_over, left_wins, right_wins, clear});
        end
        checks++;
        if (rope_led !== 9'b000000001) begin errors++; $display("FAIL over_left_led got=%b exp=000000001", rope_led); end
        checks++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            push = i[0]; right = i[1]; tie = i[2];
            tick(1);
            if (point_left | point_right | point_tie) seen++;
        end
        push = 1'b0; right = 1'b0; tie = 1'b0;
        if (seen !== 0 || pos !== 4'd0 || game_over !== 1'b1 || clear !== 1'b1) begin
            errors++; $display("FAIL over_ignore got pulses=%0d pos=%0d go=%b clear=%b exp 0 0 1 1",
                seen, pos, game_over, clear);
        end
        checks++;
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        if (pos !== 4'd4 || {game_over, left_wins, right_wins} !== 3'b000 || clear !== 1'b1) begin
            errors++; $display("FAIL newgame_state got pos=%0d flags=%b clear=%b exp pos=4 flags=000 clear=1",
                pos, {game_over, left_wins, right_wins}, clear);
        end
        checks++;
        tick(7);
        if (clear !== 1'b1) begin errors++; $display("FAIL newgame_cool got=%b exp=1", clear); end
        checks++;
        tick(1);
        if (clear !== 1'b0) begin errors++; $display("FAIL newgame_rearm got=%b exp=0", clear); end
        checks++;
    endtask

    task automatic test_reset_mid_settle;
        int seen;
        for (int k = 1; k <= 2; k++) begin
            push = 1'b1; right = 1'b1;
            tick(5);
            if (pos !== 4'(4 + k)) begin errors++; $display("FAIL rstmid_setup%0d got=%0d exp=%0d", k, pos, 4 + k); end
            checks++;
            push = 1'b0;
            tick(9);
        end
        push = 1'b1; right = 1'b1;
        tick(2);
        #2;
        rst = 1'b0;
        #1;
        if (pos !== 4'd4 || clear !== 1'b1 || rope_led !== 9'b000010000) begin
            errors++; $display("FAIL rstmid_async got pos=%0d clear=%b led=%b exp pos=4 clear=1 led=000010000",
                pos, clear, rope_led);
        end
        checks++;
        seen = 0;
        repeat (5) begin
            tick(1);
            if (point_left | point_right | point_tie) seen++;
        end
        if (seen !== 0 || pos !== 4'd4) begin
            errors++; $display("FAIL rstmid_hold got pulses=%0d pos=%0d exp 0 4", seen, pos);
        end
        checks++;
        rst = 1'b1; push = 1'b0; right = 1'b0;
        tick(8);
        if (clear !== 1'b0) begin errors++; $display("FAIL rstmid_rearm got=%b exp=0", clear); end
        checks++;
    endtask

    task automatic test_newgame_discard;
        push = 1'b1; right = 1'b0;
        tick(3);
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0; push = 1'b0;
        if (point_left !== 1'b0 || pos !== 4'd4 || clear !== 1'b1) begin
            errors++; $display("FAIL discard got pl=%b pos=%0d clear=%b exp 0 4 1", point_left, pos, clear);
        end
        checks++;
        tick(8);
        if (clear !== 1'b0) begin errors++; $display("FAIL discard_rearm got=%b exp=0", clear); end
        checks++;
    endtask

    task automatic test_back_to_back;
        int pulses;
        int exp_pos;
        pulses = 0;
        exp_pos = 4;
        push = 1'b1; right = 1'b1; tie = 1'b0;
        for (int i = 0; i < 200 && !game_over; i++) begin
            tick(1);
            if (point_right) begin
                pulses++;
                exp_pos++;
                if (pos !== 4'(exp_pos)) begin
                    errors++; $display("FAIL repeat_step got=%0d exp=%0d", pos, exp_pos);
                end
                checks++;
            end
        end
        push = 1'b0; right = 1'b0;
        if (game_over !== 1'b1) begin errors++; $display("FAIL repeat_timeout got game_over=%b exp=1", game_over); end
        checks++;
        if (pulses !== 4 || pos !== 4'd8) begin
            errors++; $display("FAIL repeat_count got pulses=%0d pos=%0d exp 4 8", pulses, pos);
        end
        checks++;
        if ({right_wins, left_wins, clear} !== 3'b101 || rope_led !== 9'b100000000) begin
            errors++; $display("FAIL repeat_flags got rw/lw/clear=%b led=%b exp 101 100000000",
                {right_wins, left_wins, clear}, rope_led);
        end
        checks++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_right_point();
        test_tie_late();
        test_glitch();
        test_left_to_over();
        test_reset_mid_settle();
        test_newgame_discard();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
